// File: rtl/modular_mul_pipe.sv
// Three-stage pipelined Montgomery multiply-reduce, LANES independent 16-bit lanes
// sharing one valid/ready handshake. S1: z=a*b, S2: z and m*Q, S3: reduced result.
module modular_mul_pipe #(
  parameter int LANES     = 2,
  parameter int Q         = 3329,
  parameter int Q_INV_NEG = 3327,
  parameter int TAG_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [16*LANES-1:0]  a_i,
  input  logic [16*LANES-1:0]  b_i,
  input  logic                 canon_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [16*LANES-1:0]  res_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 busy_o
);

  // Only the low 16 bits of the Q_INV_NEG product matter, so a plain 32-bit copy suffices.
  localparam logic signed [31:0] L_QINV = Q_INV_NEG;
  localparam logic signed [31:0] L_Q    = Q;

  // Stage valid bits and handshake helpers
  logic r_v1, r_v2, r_v3;
  logic w_stall;
  logic w_load2;
  logic w_load3;

  // Per-lane datapath
  logic signed [31:0] w_z0  [LANES];
  logic signed [31:0] r_z1  [LANES];
  logic signed [31:0] w_mq1 [LANES];
  logic signed [31:0] r_z2  [LANES];
  logic signed [31:0] r_mq2 [LANES];
  logic signed [31:0] w_t2  [LANES];
  logic signed [31:0] w_adj2[LANES];
  logic        [15:0] r_res3[LANES];

  // Sideband carried alongside the data
  logic             r_c1, r_c2;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;

  // S3 only blocks when it holds a result nobody takes; S2 may still fill if it is empty.
  always_comb begin
    w_stall     = r_v3 && !out_ready_i;
    w_load3     = !w_stall;
    w_load2     = !w_stall || !r_v2;
    in_ready_o  = !w_stall;
    out_valid_o = r_v3;
    busy_o      = r_v1 || r_v2 || r_v3;
  end

  // Stage valids: full shift when not stalled, bubble collapse into an empty S2 when stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_v1 <= in_valid_i;
      end else if (!r_v2) begin
        r_v1 <= 1'b0;
      end
      if (w_load2) begin
        r_v2 <= r_v1;
      end
      if (w_load3) begin
        r_v3 <= r_v2;
      end
    end
  end

  // Signed 16x16 product per lane feeding S1.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_z0[k] = 32'($signed(a_i[16*k +: 16])) * 32'($signed(b_i[16*k +: 16]));
    end
  end

  // S1 data registers; contents are ignored while r_v1 is low.
  always_ff @(posedge clk_i) begin
    if (!w_stall && in_valid_i) begin
      for (int k = 0; k < LANES; k++) begin
        r_z1[k] <= w_z0[k];
      end
      r_c1   <= canon_i;
      r_tag1 <= tag_i;
    end
  end

  // m = low16(z*Q_INV_NEG) taken as signed, then m*Q.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_mq1[k] = 32'(signed'(16'(r_z1[k] * L_QINV))) * L_Q;
    end
  end

  // S2 data registers; contents are ignored while r_v2 is low.
  always_ff @(posedge clk_i) begin
    if (w_load2 && r_v1) begin
      for (int k = 0; k < LANES; k++) begin
        r_z2[k]  <= r_z1[k];
        r_mq2[k] <= w_mq1[k];
      end
      r_c2   <= r_c1;
      r_tag2 <= r_tag1;
    end
  end

  // t = (z + m*Q) >>> 16; canonical mode folds t into [0,Q).
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_t2[k]   = (r_z2[k] + r_mq2[k]) >>> 16;
      w_adj2[k] = w_t2[k];
      if (r_c2) begin
        if (w_t2[k] < 0) begin
          w_adj2[k] = w_t2[k] + L_Q;
        end else if (w_t2[k] >= L_Q) begin
          w_adj2[k] = w_t2[k] - L_Q;
        end
      end
    end
  end

  // S3 is the output register; it only changes when a valid S2 entry moves in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < LANES; k++) begin
        r_res3[k] <= '0;
      end
      r_tag3 <= '0;
    end else if (w_load3 && r_v2) begin
      for (int k = 0; k < LANES; k++) begin
        r_res3[k] <= 16'(w_adj2[k]);
      end
      r_tag3 <= r_tag2;
    end
  end

  // Pack lane results onto the output bus.
  always_comb begin
    res_o = '0;
    for (int k = 0; k < LANES; k++) begin
      res_o[16*k +: 16] = r_res3[k];
    end
    tag_o = r_tag3;
  end

endmodule

// File: tb/tb_modular_mul_pipe.sv
// Self-checking bench for modular_mul_pipe: directed known-answer tests, backpressure,
// reset mid-stream, and a randomized regression against an arithmetic reference model.
module tb_modular_mul_pipe;
  localparam int LANES = 2;
  localparam int Q     = 3329;
  localparam int QINV  = 3327;
  localparam int TAG_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       a_i;
  logic [31:0]       b_i;
  logic              canon_i;
  logic [TAG_W-1:0]  tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       res_o;
  logic [TAG_W-1:0]  tag_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  int popped = 0;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             canon;
  } exp_t;
  exp_t sb[$];

  logic             prevStall = 1'b0;
  logic [31:0]      prevRes;
  logic [TAG_W-1:0] prevTag;

  modular_mul_pipe #(.LANES(LANES), .Q(Q), .Q_INV_NEG(QINV), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .canon_i(canon_i), .tag_i(tag_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .res_o(res_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // Montgomery reduction written directly from its arithmetic definition.
  function automatic logic [15:0] refLane(input int a, input int b, input bit canon);
    longint z = longint'(a) * longint'(b);
    longint p = z * QINV;
    longint m = p & 64'hFFFF;
    longint t;
    if (m >= 32768) m -= 65536;
    t = (z + m * Q) / 65536;
    if (canon) begin
      if (t < 0) t += Q;
      else if (t >= Q) t -= Q;
    end
    return 16'(t);
  endfunction

  function automatic logic [31:0] refTxn(input logic [31:0] a, input logic [31:0] b, input bit canon);
    logic [31:0] r;
    for (int k = 0; k < LANES; k++) begin
      r[16*k +: 16] = refLane(int'($signed(a[16*k +: 16])), int'($signed(b[16*k +: 16])), canon);
    end
    return r;
  endfunction

  // Operands with |a*b| < Q*2^15: one side bounded by 3328, the other full 16-bit.
  task automatic randOperands(output logic [31:0] a, output logic [31:0] b);
    int x, y, s;
    for (int k = 0; k < LANES; k++) begin
      x = int'($urandom_range(6656)) - 3328;
      y = int'($urandom_range(65535)) - 32768;
      if ($urandom_range(1) == 1) begin
        s = x; x = y; y = s;
      end
      a[16*k +: 16] = 16'(x);
      b[16*k +: 16] = 16'(y);
    end
  endtask

  // One cycle of streaming: drive at negedge, then score handshakes that the next posedge will complete.
  task automatic driveCycle(input logic vld, input logic [31:0] a, input logic [31:0] b,
                            input logic canon, input logic [TAG_W-1:0] tag, input logic rdy,
                            output logic accepted);
    exp_t e;
    @(negedge clk_i);
    in_valid_i  = vld;
    a_i         = a;
    b_i         = b;
    canon_i     = canon;
    tag_i       = tag;
    out_ready_i = rdy;
    #1;
    if (prevStall) begin
      check("hold_valid", 32'(out_valid_o), 32'd1);
      check("hold_res", res_o, prevRes);
      check("hold_tag", 32'(tag_o), 32'(prevTag));
    end
    check("in_ready", 32'(in_ready_o), 32'(!(out_valid_o && !out_ready_i)));
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(out_valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        popped++;
        check("res", res_o, e.res);
        check("tag", 32'(tag_o), 32'(e.tag));
        if (e.canon) begin
          for (int k = 0; k < LANES; k++) begin
            check("canon_range", 32'($signed(res_o[16*k +: 16]) >= 0 && $signed(res_o[16*k +: 16]) < Q), 32'd1);
          end
        end
      end
    end
    accepted = vld && in_ready_o;
    if (accepted) begin
      e.res   = refTxn(a, b, canon);
      e.tag   = tag;
      e.canon = canon;
      sb.push_back(e);
    end
    prevStall = out_valid_o && !out_ready_i;
    prevRes   = res_o;
    prevTag   = tag_o;
  endtask

  // Single transaction into an empty pipeline, accepted on the next rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic canon,
                               input logic [TAG_W-1:0] tag);
    @(negedge clk_i);
    in_valid_i  = 1'b1;
    a_i         = a;
    b_i         = b;
    canon_i     = canon;
    tag_i       = tag;
    out_ready_i = 1'b1;
    #1;
    check("accept_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  // Wait (bounded) for the result and check value, tag and three-cycle latency.
  task automatic checkOutput(input string name, input logic [31:0] expRes, input logic [TAG_W-1:0] expTag);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!out_valid_o && n < 10);
    check({name, "_latency"}, 32'(n), 32'd3);
    check({name, "_res"}, res_o, expRes);
    check({name, "_tag"}, 32'(tag_o), 32'(expTag));
  endtask

  initial begin
    logic        acc;
    logic [31:0] ra, rb;
    int          idx, cyc, sent;
    logic        sawStall;

    // Reset state
    rst_ni = 1'b0; in_valid_i = 1'b0; a_i = '0; b_i = '0; canon_i = 1'b0; tag_i = '0; out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_res", res_o, 32'd0);
    check("rst_tag", 32'(tag_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Known-answer tests
    $display("[TB] directed tests");
    applyStimulus({16'd1, 16'd0}, {16'd1, 16'd5}, 1'b0, 4'd1);
    checkOutput("unity", {16'd169, 16'd0}, 4'd1);
    applyStimulus({16'hFFFF, 16'hFFFF}, {16'd1, 16'd1}, 1'b0, 4'd2);
    checkOutput("neg_raw", {16'hFF57, 16'hFF57}, 4'd2);
    applyStimulus({16'hFFFF, 16'hFFFF}, {16'd1, 16'd1}, 1'b1, 4'd3);
    checkOutput("neg_canon", {16'd3160, 16'd3160}, 4'd3);
    applyStimulus({16'd3328, 16'd3328}, {16'd3328, 16'd3328}, 1'b0, 4'd4);
    checkOutput("max_raw", {16'd169, 16'd169}, 4'd4);
    applyStimulus({16'd3328, 16'd3328}, {16'd3328, 16'd3328}, 1'b1, 4'd5);
    checkOutput("max_canon", {16'd169, 16'd169}, 4'd5);
    @(negedge clk_i);
    check("idle_busy", 32'(busy_o), 32'd0);

    // Backpressure: 8 tagged transactions, downstream stalls for 5 cycles mid-stream
    $display("[TB] backpressure");
    sb.delete(); popped = 0; prevStall = 1'b0; idx = 0; cyc = 0; sawStall = 1'b0;
    while ((idx < 8 || sb.size() > 0) && cyc < 100) begin
      randOperands(ra, rb);
      driveCycle(idx < 8, ra, rb, 1'($urandom_range(1)), 4'(idx), !(cyc >= 5 && cyc < 10), acc);
      if (!in_ready_o) sawStall = 1'b1;
      if (acc) idx++;
      cyc++;
    end
    check("bp_count", 32'(popped), 32'd8);
    check("bp_saw_stall", 32'(sawStall), 32'd1);

    // Reset with three transactions in flight
    $display("[TB] reset mid-stream");
    sb.delete(); popped = 0; prevStall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randOperands(ra, rb);
      driveCycle(1'b1, ra, rb, 1'b0, 4'(8 + i), 1'b0, acc);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    check("inflight_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_in_ready", 32'(in_ready_o), 32'd1);
    sb.delete(); prevStall = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      driveCycle(1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
      check("no_stale", 32'(out_valid_o), 32'd0);
    end
    applyStimulus({16'd7, 16'hFFF9}, {16'd100, 16'd300}, 1'b1, 4'd12);
    checkOutput("post_rst", refTxn({16'd7, 16'hFFF9}, {16'd100, 16'd300}, 1'b1), 4'd12);

    // Random regression: 5000 transactions x 2 lanes, random canon/valid/ready
    $display("[TB] random regression");
    @(negedge clk_i);
    sb.delete(); popped = 0; prevStall = 1'b0; sent = 0; cyc = 0;
    while ((sent < 5000 || sb.size() > 0) && cyc < 40000) begin
      randOperands(ra, rb);
      driveCycle(sent < 5000 && $urandom_range(99) < 80, ra, rb, 1'($urandom_range(1)),
                 4'($urandom_range(15)), $urandom_range(99) < 75, acc);
      if (acc) sent++;
      cyc++;
    end
    check("rand_count", 32'(popped), 32'd5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
